// File: rtl/pio_tx_fifo.sv
// Transmit FIFO between the PIO register file (TXF writes) and the state
// machine OSR (PULL). Reports fill level, full/empty and sticky TXOVER/TXSTALL.
module pio_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pull_req,
  input  logic                     pull_block,
  input  logic [WIDTH-1:0]         x_in,
  output logic                     pull_valid,
  output logic [WIDTH-1:0]         pull_data,
  output logic                     pull_stall,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     txover,
  output logic                     txstall,
  input  logic                     clr_over,
  input  logic                     clr_stall,
  input  logic                     fifo_clear
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pull_valid_q, pull_valid_d;
  logic [WIDTH-1:0] pull_data_q, pull_data_d;
  logic             txover_q, txover_d;
  logic             txstall_q, txstall_d;

  logic             empty_w;
  logic             full_w;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty_w = (count_q == CW'(0));
  assign full_w  = (count_q == CW'(DEPTH));

  // Pop, push and overflow decisions; a pop frees a slot for a same-cycle push
  always_comb begin
    do_pop  = pull_req & ~empty_w & ~fifo_clear;
    do_push = wr_en & (~full_w | do_pop) & ~fifo_clear;
    drop    = wr_en & full_w & ~do_pop & ~fifo_clear;
  end

  // Next-state for pointers, count, storage and pull output
  always_comb begin
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pull_valid_d = 1'b0;
    pull_data_d  = pull_data_q;

    if (fifo_clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
      end
      if (do_pop) begin
        rd_ptr_d     = PW'(rd_ptr_q + PW'(1));
        pull_valid_d = 1'b1;
        pull_data_d  = mem_q[rd_ptr_q];
      end else if (pull_req && !pull_block) begin
        pull_valid_d = 1'b1;
        pull_data_d  = x_in;
      end
      if (do_push && !do_pop) begin
        count_d = CW'(count_q + CW'(1));
      end else if (do_pop && !do_push) begin
        count_d = CW'(count_q - CW'(1));
      end
    end
  end

  // Sticky flags: set wins over write-1-to-clear
  always_comb begin
    txover_d  = txover_q;
    txstall_d = txstall_q;
    if (clr_over) txover_d = 1'b0;
    if (clr_stall) txstall_d = 1'b0;
    if (drop) txover_d = 1'b1;
    if (pull_stall && !fifo_clear) txstall_d = 1'b1;
  end

  // Control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pull_valid_q <= 1'b0;
      pull_data_q  <= '0;
      txover_q     <= 1'b0;
      txstall_q    <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pull_valid_q <= pull_valid_d;
      pull_data_q  <= pull_data_d;
      txover_q     <= txover_d;
      txstall_q    <= txstall_d;
    end
  end

  // Storage array; contents are never read before being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pull_stall = pull_req & pull_block & empty_w;
  assign pull_valid = pull_valid_q;
  assign pull_data  = pull_data_q;
  assign level      = count_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign txover     = txover_q;
  assign txstall    = txstall_q;

endmodule
